// File: rtl/nn_pkg.sv
// Shared types, defaults and arithmetic helpers for the fixed-point neuron.
package nn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC,
        ST_FLUSH,
        ST_FINAL,
        ST_DONE
    } state_e;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned FRAC_BITS  = 8;

    function automatic int unsigned acc_width(input int unsigned weight_no, input int unsigned dw);
        return 2 * dw + $clog2(weight_no);
    endfunction

    function automatic int unsigned addr_width(input int unsigned weight_no);
        return (weight_no > 1) ? $clog2(weight_no) : 1;
    endfunction

    // The lower saturation bound is never reached: ReLU clamps every negative result to 0.
    function automatic logic [63:0] sat_relu(input logic signed [63:0] sum,
                                             input int unsigned dw,
                                             input int unsigned fb);
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        r     = sum >>> fb;
        max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
        if (r < 0)
            return '0;
        else if (r > max_v)
            return max_v;
        else
            return r;
    endfunction

endpackage

// File: rtl/neuron_mac_pipe.sv
// Product and accumulate registers of the neuron's serial multiply-accumulate.
module mac_pipe
    import nn_pkg::*;
#(
    parameter int unsigned DW    = DATA_WIDTH,
    parameter int unsigned ACC_W = 2 * DATA_WIDTH + 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    valid_i,
    input  logic signed [DW-1:0]    a_i,
    input  logic signed [DW-1:0]    b_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [2*DW-1:0]  prod_q;
    logic                    prod_vld_q;
    logic signed [ACC_W-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_vld_q <= valid_i;
            if (valid_i)
                prod_q <= (2*DW)'(a_i) * (2*DW)'(b_i);
            if (prod_vld_q)
                acc_q <= acc_q + ACC_W'(prod_q);
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/neuron_mac.sv
// One fixed-point neuron: serial MAC over a weight ROM, then bias, saturation and ReLU.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int unsigned weightNo  = 784,
    parameter int unsigned dataWidth = DATA_WIDTH,
    parameter int unsigned fracBits  = FRAC_BITS
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [weightNo*dataWidth-1:0]         in,
    output logic                                  weight_en,
    output logic [addr_width(weightNo)-1:0]       weight_addr,
    input  logic [dataWidth-1:0]                  weight_data,
    input  logic [dataWidth-1:0]                  bias,
    output logic [dataWidth-1:0]                  out,
    output logic                                  done,
    output logic                                  busy
);

    localparam int unsigned AW    = addr_width(weightNo);
    localparam int unsigned ACC_W = acc_width(weightNo, dataWidth);
    localparam logic [AW-1:0] LAST_ADDR = AW'(weightNo - 1);

    state_e                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic                    en_q, en_d;
    logic                    flush_q, flush_d;
    logic [dataWidth-1:0]    out_q, out_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    clear;

    // ROM data arrives one edge after the address, so the input index trails by one.
    logic [AW-1:0]           addr_dly_q;
    logic                    en_dly_q;
    logic [dataWidth-1:0]    in_sel;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            en_q       <= 1'b0;
            flush_q    <= 1'b0;
            out_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            addr_dly_q <= '0;
            en_dly_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            en_q       <= en_d;
            flush_q    <= flush_d;
            out_q      <= out_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            addr_dly_q <= addr_q;
            en_dly_q   <= en_q;
        end
    end

    always_comb begin
        in_sel = in[32'(addr_dly_q) * dataWidth +: dataWidth];
        sum    = acc + ((ACC_W'(signed'(bias))) <<< fracBits);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        en_d    = 1'b0;
        flush_d = flush_q;
        out_d   = out_q;
        done_d  = done_q;
        busy_d  = busy_q;
        clear   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_MAC;
                    addr_d  = '0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    clear   = 1'b1;
                end
            end
            ST_MAC: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_FLUSH;
                    flush_d = 1'b0;
                end else begin
                    addr_d = addr_q + 1'b1;
                    en_d   = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_q)
                    state_d = ST_FINAL;
                else
                    flush_d = 1'b1;
            end
            ST_FINAL: begin
                out_d   = dataWidth'(sat_relu(64'(sum), dataWidth, fracBits));
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mac_pipe #(
        .DW    (dataWidth),
        .ACC_W (ACC_W)
    ) u_mac_pipe (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear),
        .valid_i (en_dly_q),
        .a_i     (signed'(in_sel)),
        .b_i     (signed'(weight_data)),
        .acc_o   (acc)
    );

    assign weight_en   = en_q;
    assign weight_addr = addr_q;
    assign out         = out_q;
    assign done        = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed vector bench for neuron_mac with weightNo=4 and a modelled synchronous weight ROM.
module tb_neuron_mac;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;

    typedef struct {
        logic [15:0] in_v [4];
        logic [15:0] w_v  [4];
        logic [15:0] bias_v;
        logic [15:0] exp_out;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [N*DW-1:0]   in_bus = '0;
    logic              weight_en;
    logic [1:0]        weight_addr;
    logic [DW-1:0]     weight_data = '0;
    logic [DW-1:0]     bias = '0;
    logic [DW-1:0]     out;
    logic              done;
    logic              busy;

    logic [DW-1:0]     rom [4];
    vec_t              vecs [6];
    int                tests = 0;
    int                failed = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (weight_en) weight_data <= rom[weight_addr];

    neuron_mac #(
        .weightNo  (N),
        .dataWidth (DW),
        .fracBits  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in          (in_bus),
        .weight_en   (weight_en),
        .weight_addr (weight_addr),
        .weight_data (weight_data),
        .bias        (bias),
        .out         (out),
        .done        (done),
        .busy        (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input int idx);
        for (int k = 0; k < 4; k++) begin
            in_bus[k*DW +: DW] = vecs[idx].in_v[k];
            rom[k]             = vecs[idx].w_v[k];
        end
        bias = vecs[idx].bias_v;
    endtask

    // Full transaction from the accepting edge (edge 0) to the result on edge N+3.
    task automatic run_vec(input int idx);
        load(idx);
        start = 1'b1;
        step();
        start = 1'b0;
        check($sformatf("v%0d edge0 addr", idx), 32'(weight_addr), 32'd0);
        check($sformatf("v%0d edge0 busy/done/en", idx), {29'd0, busy, done, weight_en}, 32'b101);
        for (int e = 1; e < 4; e++) begin
            step();
            check($sformatf("v%0d edge%0d addr/en", idx, e), {29'd0, weight_en, weight_addr}, {29'd0, 1'b1, 2'(e)});
        end
        step();
        check($sformatf("v%0d edge4 en off", idx), 32'(weight_en), 32'd0);
        step();
        step();
        check($sformatf("v%0d edge6 not done", idx), {30'd0, busy, done}, 32'b10);
        step();
        check($sformatf("v%0d edge7 done/busy", idx), {30'd0, busy, done}, 32'b01);
        check($sformatf("v%0d out", idx), 32'(out), 32'(vecs[idx].exp_out));
    endtask

    initial begin
        vecs[0] = '{in_v: '{16'h0100, 16'h0100, 16'h0100, 16'h0100}, w_v: '{16'h0100, 16'h0100, 16'h0100, 16'h0100}, bias_v: 16'h0000, exp_out: 16'h0400};
        vecs[1] = '{in_v: '{16'h0180, 16'h0180, 16'h0180, 16'h0180}, w_v: '{16'h0080, 16'h0080, 16'h0080, 16'h0080}, bias_v: 16'h0040, exp_out: 16'h0340};
        vecs[2] = '{in_v: '{16'h0001, 16'h0001, 16'h0001, 16'h0001}, w_v: '{16'h0001, 16'h0001, 16'h0001, 16'h0001}, bias_v: 16'h0000, exp_out: 16'h0000};
        vecs[3] = '{in_v: '{16'h0100, 16'h0100, 16'h0100, 16'h0100}, w_v: '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00}, bias_v: 16'h0000, exp_out: 16'h0000};
        vecs[4] = '{in_v: '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, w_v: '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, bias_v: 16'h7FFF, exp_out: 16'h7FFF};
        // 1*1 + 2*0.5 + 3*(-0.5) + 4*0.25 = 1.5
        vecs[5] = '{in_v: '{16'h0100, 16'h0200, 16'h0300, 16'h0400}, w_v: '{16'h0100, 16'h0080, 16'hFF80, 16'h0040}, bias_v: 16'h0000, exp_out: 16'h0180};
        for (int k = 0; k < 4; k++) rom[k] = '0;

        rst = 1'b1;
        step();
        step();
        check("reset outputs", {11'd0, weight_en, weight_addr, busy, done, out}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec(i);
            step();
        end

        // start pulses during MAC must not restart or extend the sweep
        begin
            int en_cnt;
            int done_low;
            en_cnt = 0;
            load(5);
            start = 1'b1;
            step();
            if (weight_en) en_cnt++;
            step();
            if (weight_en) en_cnt++;
            step();
            if (weight_en) en_cnt++;
            start = 1'b0;
            for (int e = 3; e < 8; e++) begin
                if (e == 7) check("hs edge6 not done", 32'(done), 32'd0);
                step();
                if (weight_en) en_cnt++;
            end
            check("hs single sweep", 32'(en_cnt), 32'd4);
            check("hs done on time", {30'd0, busy, done}, 32'b01);
            check("hs out", 32'(out), 32'h0180);

            done_low = 0;
            for (int c = 0; c < 20; c++) begin
                step();
                if (!done || busy || weight_en) done_low++;
            end
            check("done holds", 32'(done_low), 32'd0);
            check("out holds", 32'(out), 32'h0180);
        end

        // restart while done: done falls on the accepting edge
        load(1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart done falls", {29'd0, busy, done, weight_en}, 32'b101);
        check("restart addr0", 32'(weight_addr), 32'd0);
        check("restart out kept", 32'(out), 32'h0180);
        for (int e = 1; e < 7; e++) step();
        check("restart edge6 not done", 32'(done), 32'd0);
        step();
        check("restart edge7 done", 32'(done), 32'd1);
        check("restart out", 32'(out), 32'h0340);
        step();

        // reset mid-MAC aborts; next computation must not see stale accumulation
        load(4);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("midmac reset outputs", {11'd0, weight_en, 2'b00, busy, done, out}, 32'd0);
        step();
        rst = 1'b0;
        begin
            int done_seen;
            done_seen = 0;
            for (int c = 0; c < 10; c++) begin
                step();
                if (done) done_seen++;
            end
            check("no done after abort", 32'(done_seen), 32'd0);
        end
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
